// File: rtl/ahb_mem_sram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_mem_sram_ctrl_if
// Purpose  : Bundles the command handshake, read-return and SRAM-side signals
//            of the memory-side SRAM controller.
// Revision : 1.0 - initial release
// ============================================================================
interface ahb_mem_sram_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_AW     = 10
);
  // Command side (from the AHB slave's memory port)
  logic                  i_valid;
  logic                  i_rd0_wr1;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  o_ready;
  logic                  o_rd_valid;
  logic [DATA_WIDTH-1:0] o_rd_data;

  // SRAM side
  logic                  o_mem_cs;
  logic                  o_mem_we;
  logic [MEM_AW-1:0]     o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic [DATA_WIDTH-1:0] i_mem_rdata;

  // Environment view: issues commands and models the SRAM
  modport master (
    output i_valid, i_rd0_wr1, i_addr, i_wr_data, i_mem_rdata,
    input  o_ready, o_rd_valid, o_rd_data,
    input  o_mem_cs, o_mem_we, o_mem_addr, o_mem_wdata
  );

  // Controller view
  modport slave (
    input  i_valid, i_rd0_wr1, i_addr, i_wr_data, i_mem_rdata,
    output o_ready, o_rd_valid, o_rd_data,
    output o_mem_cs, o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/ahb_mem_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ahb_mem_sram_ctrl
// Purpose  : Buffers read/write commands in a small FIFO and issues them in
//            order to a single-port synchronous SRAM with fixed read latency.
//            Reads return through a one-cycle o_rd_valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_mem_sram_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_AW     = 10,
  parameter int FIFO_DEPTH = 4,   // power of 2, >= 2
  parameter int RD_LATENCY = 1    // 1..7
) (
  input wire                 i_clk_ahb,
  input wire                 i_rstn_ahb,
  ahb_mem_sram_ctrl_if.slave bus
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_ENT_W = 1 + MEM_AW + DATA_WIDTH;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);
  localparam logic [2:0]         c_LAT  = 3'(RD_LATENCY);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_WAIT_RD = 1'b1
  } state_t;

  // FIFO storage and bookkeeping; entry = {rd0_wr1, word address, write data}
  logic [c_ENT_W-1:0]    fifo_q [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    wr_ptr_q;
  logic [c_PTR_W-1:0]    rd_ptr_q;
  logic [c_CNT_W-1:0]    count_q;
  logic [c_CNT_W-1:0]    count_d;
  logic                  ready_q;

  // Sequencer state and read-return registers
  state_t                state_q;
  logic [2:0]            lat_cnt_q;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic                  w_push;
  logic                  w_pop;
  logic [c_ENT_W-1:0]    w_head;
  logic                  w_head_wr;
  logic [MEM_AW-1:0]     w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;

  // Only the word-address bits reach the SRAM; the rest alias away.
  if (ADDR_WIDTH > MEM_AW + 2) begin : g_addr_hi_unused
    logic w_addr_unused;
    assign w_addr_unused = ^{bus.i_addr[ADDR_WIDTH-1:MEM_AW+2], bus.i_addr[1:0]};
  end else begin : g_addr_lo_unused
    logic w_addr_unused;
    assign w_addr_unused = ^bus.i_addr[1:0];
  end

  assign w_push      = bus.i_valid && ready_q;
  assign w_pop       = (state_q == ST_IDLE) && (count_q != '0);
  assign w_head      = fifo_q[rd_ptr_q];
  assign w_head_wr   = w_head[c_ENT_W-1];
  assign w_head_addr = w_head[DATA_WIDTH +: MEM_AW];
  assign w_head_data = w_head[DATA_WIDTH-1:0];

  // Occupancy update: simultaneous push and pop cancel out
  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_CNT_W'(1);
      2'b01:   count_d = count_q - c_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Command storage: entries are written on accept, never cleared
  always_ff @(posedge i_clk_ahb) begin
    if (w_push) begin
      fifo_q[wr_ptr_q] <= {bus.i_rd0_wr1, bus.i_addr[MEM_AW+1:2], bus.i_wr_data};
    end
  end

  // Pointers, count and ready flag; ready follows the registered count so a
  // pop in the full cycle cannot admit a push in that same cycle
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
      count_q <= count_d;
      ready_q <= (count_d != c_FULL);
    end
  end

  // Sequencer: one SRAM access per popped command, one read in flight
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      state_q    <= ST_IDLE;
      lat_cnt_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_pop && !w_head_wr) begin
            state_q   <= ST_WAIT_RD;
            lat_cnt_q <= c_LAT;
          end
        end
        ST_WAIT_RD: begin
          if (lat_cnt_q == 3'd1) begin
            rd_data_q  <= bus.i_mem_rdata;
            rd_valid_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            lat_cnt_q <= lat_cnt_q - 3'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // SRAM strobes come straight from the FIFO head in the pop cycle
  assign bus.o_mem_cs    = w_pop;
  assign bus.o_mem_we    = w_pop && w_head_wr;
  assign bus.o_mem_addr  = w_pop ? w_head_addr : '0;
  assign bus.o_mem_wdata = w_pop ? w_head_data : '0;

  assign bus.o_ready     = ready_q;
  assign bus.o_rd_valid  = rd_valid_q;
  assign bus.o_rd_data   = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_mem_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_mem_sram_ctrl
// Purpose  : Directed self-checking bench; instance A uses RD_LATENCY=1,
//            instance B uses RD_LATENCY=3. Each has its own SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_mem_sram_ctrl;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ahb_mem_sram_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_AW(10)) bus_a ();
  ahb_mem_sram_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_AW(10)) bus_b ();

  ahb_mem_sram_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_AW(10), .FIFO_DEPTH(4), .RD_LATENCY(1)
  ) u_dut_a (
    .i_clk_ahb (clk),
    .i_rstn_ahb(rstn),
    .bus       (bus_a)
  );

  ahb_mem_sram_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_AW(10), .FIFO_DEPTH(4), .RD_LATENCY(3)
  ) u_dut_b (
    .i_clk_ahb (clk),
    .i_rstn_ahb(rstn),
    .bus       (bus_b)
  );

  // SRAM models: read data is valid only in the cycle RD_LATENCY after cs,
  // otherwise a poison pattern is presented
  logic [31:0] mem_a [1024];
  logic [31:0] rp_a;
  logic [31:0] mem_b [1024];
  logic [31:0] rp_b  [3];

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t log_b [$];

  always @(posedge clk) begin
    if (bus_a.o_mem_cs && bus_a.o_mem_we) mem_a[bus_a.o_mem_addr] <= bus_a.o_mem_wdata;
    rp_a <= (bus_a.o_mem_cs && !bus_a.o_mem_we) ? mem_a[bus_a.o_mem_addr] : 32'hBAD0_0BAD;
  end
  assign bus_a.i_mem_rdata = rp_a;

  always @(posedge clk) begin
    if (bus_b.o_mem_cs && bus_b.o_mem_we) begin
      mem_b[bus_b.o_mem_addr] <= bus_b.o_mem_wdata;
      log_b.push_back('{a: bus_b.o_mem_addr, d: bus_b.o_mem_wdata});
    end
    rp_b[0] <= (bus_b.o_mem_cs && !bus_b.o_mem_we) ? mem_b[bus_b.o_mem_addr] : 32'hBAD0_0BAD;
    rp_b[1] <= rp_b[0];
    rp_b[2] <= rp_b[1];
  end
  assign bus_b.i_mem_rdata = rp_b[2];

  // Full-FIFO stimulus for instance B, one row per cycle
  logic        f_v   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic        f_rw  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [31:0] f_ad  [7] = '{32'h40, 32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h110};
  logic [31:0] f_d   [7] = '{32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA4};
  logic        f_rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_a(input logic v, input logic rw, input logic [31:0] ad, input logic [31:0] d);
    bus_a.i_valid   = v;
    bus_a.i_rd0_wr1 = rw;
    bus_a.i_addr    = ad;
    bus_a.i_wr_data = d;
  endtask

  task automatic drive_b(input logic v, input logic rw, input logic [31:0] ad, input logic [31:0] d);
    bus_b.i_valid   = v;
    bus_b.i_rd0_wr1 = rw;
    bus_b.i_addr    = ad;
    bus_b.i_wr_data = d;
  endtask

  task automatic wait_rd_a(input string tag, input logic [31:0] exp);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus_a.o_rd_valid) begin
        seen = 1'b1;
        chk(tag, bus_a.o_rd_data, exp);
      end
    end
    if (!seen) chk({tag, "_timeout"}, 32'(bus_a.o_rd_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    drive_b(1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    mid();
    chk("rst_rdy_a",  32'(bus_a.o_ready),    32'd1);
    chk("rst_rdv_a",  32'(bus_a.o_rd_valid), 32'd0);
    chk("rst_cs_a",   32'(bus_a.o_mem_cs),   32'd0);
    chk("rst_rdat_a", bus_a.o_rd_data,       32'd0);
    chk("rst_rdy_b",  32'(bus_b.o_ready),    32'd1);
    chk("rst_cs_b",   32'(bus_b.o_mem_cs),   32'd0);

    // Single write: SRAM access in the cycle after acceptance
    next_cyc();
    drive_a(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    mid();
    chk("wr_rdy",      32'(bus_a.o_ready),  32'd1);
    chk("wr_nobypass", 32'(bus_a.o_mem_cs), 32'd0);
    next_cyc();
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    mid();
    chk("wr_cs",    32'(bus_a.o_mem_cs), 32'd1);
    chk("wr_we",    32'(bus_a.o_mem_we), 32'd1);
    chk("wr_addr",  32'(bus_a.o_mem_addr), 32'd4);
    chk("wr_wdata", bus_a.o_mem_wdata,   32'hDEAD_BEEF);

    // Single read, RD_LATENCY=1: pulse in cycle 3 only
    next_cyc();
    drive_a(1'b1, 1'b0, 32'h10, 32'h0);
    next_cyc();
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    mid();
    chk("rd_c1_cs",   32'(bus_a.o_mem_cs),   32'd1);
    chk("rd_c1_we",   32'(bus_a.o_mem_we),   32'd0);
    chk("rd_c1_addr", 32'(bus_a.o_mem_addr), 32'd4);
    chk("rd_c1_rdv",  32'(bus_a.o_rd_valid), 32'd0);
    next_cyc();
    mid();
    chk("rd_c2_rdv", 32'(bus_a.o_rd_valid), 32'd0);
    chk("rd_c2_cs",  32'(bus_a.o_mem_cs),   32'd0);
    next_cyc();
    mid();
    chk("rd_c3_rdv",  32'(bus_a.o_rd_valid), 32'd1);
    chk("rd_c3_data", bus_a.o_rd_data,       32'hDEAD_BEEF);
    next_cyc();
    mid();
    chk("rd_c4_rdv",  32'(bus_a.o_rd_valid), 32'd0);
    chk("rd_c4_hold", bus_a.o_rd_data,       32'hDEAD_BEEF);

    // Back-to-back write/read pairs to one address keep order
    next_cyc();
    drive_a(1'b1, 1'b1, 32'h20, 32'h1);
    next_cyc();
    drive_a(1'b1, 1'b0, 32'h20, 32'h0);
    next_cyc();
    drive_a(1'b1, 1'b1, 32'h20, 32'h2);
    next_cyc();
    drive_a(1'b1, 1'b0, 32'h20, 32'h0);
    next_cyc();
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    wait_rd_a("b2b_rd1", 32'h1);
    wait_rd_a("b2b_rd2", 32'h2);

    // Address aliasing: low and high byte-address bits are dropped
    next_cyc();
    drive_a(1'b1, 1'b1, 32'hFFFF_F013, 32'h1234_5678);
    next_cyc();
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    mid();
    chk("alias_addr", 32'(bus_a.o_mem_addr), 32'd4);
    next_cyc();
    drive_a(1'b1, 1'b0, 32'h10, 32'h0);
    next_cyc();
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    wait_rd_a("alias_rd", 32'h1234_5678);

    // RD_LATENCY=3: read at cycle 0 gives a single pulse at cycle 5
    next_cyc();
    drive_b(1'b1, 1'b1, 32'h40, 32'hCAFE_F00D);
    next_cyc();
    drive_b(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) next_cyc();
    drive_b(1'b1, 1'b0, 32'h40, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      next_cyc();
      if (k == 1) drive_b(1'b0, 1'b0, 32'h0, 32'h0);
      mid();
      chk($sformatf("lat3_rdv_c%0d", k), 32'(bus_b.o_rd_valid), (k == 5) ? 32'd1 : 32'd0);
      if (k == 5) chk("lat3_data", bus_b.o_rd_data, 32'hCAFE_F00D);
    end
    repeat (3) next_cyc();

    // Fill the FIFO during a long WAIT_RD; ready drops, then recovers
    log_b.delete();
    for (int c = 0; c < 7; c++) begin
      drive_b(f_v[c], f_rw[c], f_ad[c], f_d[c]);
      mid();
      chk($sformatf("full_rdy_c%0d", c), 32'(bus_b.o_ready),    32'(f_rdy[c]));
      chk($sformatf("full_rdv_c%0d", c), 32'(bus_b.o_rd_valid), (c == 5) ? 32'd1 : 32'd0);
      if (c == 5) chk("full_rdata", bus_b.o_rd_data, 32'hCAFE_F00D);
      next_cyc();
    end
    drive_b(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (12) next_cyc();
    chk("full_nwr", 32'(log_b.size()), 32'd5);
    for (int i = 0; i < 5 && i < log_b.size(); i++) begin
      chk($sformatf("full_wa%0d", i), 32'(log_b[i].a), 32'h40 + 32'(i));
      chk($sformatf("full_wd%0d", i), log_b[i].d,      32'hA0 + 32'(i));
    end

    // Reset during WAIT_RD with two writes queued
    drive_b(1'b1, 1'b0, 32'h40, 32'h0);
    next_cyc();
    drive_b(1'b1, 1'b1, 32'h200, 32'h55);
    next_cyc();
    drive_b(1'b1, 1'b1, 32'h204, 32'h66);
    next_cyc();
    drive_b(1'b0, 1'b0, 32'h0, 32'h0);
    #2 rstn = 1'b0;
    log_b.delete();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      mid();
      chk($sformatf("rstw_rdv_c%0d", k), 32'(bus_b.o_rd_valid), 32'd0);
      chk($sformatf("rstw_cs_c%0d", k),  32'(bus_b.o_mem_cs),   32'd0);
      chk($sformatf("rstw_rdy_c%0d", k), 32'(bus_b.o_ready),    32'd1);
      next_cyc();
    end
    chk("rstw_rdata", bus_b.o_rd_data,        32'd0);
    chk("rstw_nwr",   32'(log_b.size()),      32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
